// File: rtl/tdm_demux_1to8.sv
// Purpose : receive end of an 8:1 TDM link; rebuilds one LANES-bit word from a serial
//           stream (slot k carries lane k, LSB first) and drives the slot select back.
// Latency : out/out_valid update on the edge that samples the last slot's beat.
// Backpressure: word held behind valid/ready; a new word overwrites an unconsumed one
//           and pulses overrun for one cycle (no stall of the serial stream).
//
// Ports:
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   frame_sync        first slot of a frame (qualified by in_valid)
//   in_valid, in_bit  serial beat
//   sel_out           slot index expected next
//   out, out_valid    completed word and its valid flag
//   out_ready         consumer accept
//   overrun           1-cycle pulse when an unconsumed word is overwritten
//   parity_err        only when TDM_DEMUX_PARITY_EN is defined: even-parity check of
//                     the trailing parity slot, registered with out
//
// Optional feature macro: TDM_DEMUX_PARITY_EN (adds a parity slot after slot LANES-1).

module tdm_demux_1to8 #(
    parameter int LANES = 8,
    parameter int SEL_W = 3,
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW = SEL_W + 1
`else
    localparam int SW = SEL_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_sync,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic [SW-1:0]    sel_out,
    output logic [LANES-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef TDM_DEMUX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

`ifdef TDM_DEMUX_PARITY_EN
    typedef enum logic [1:0] {SYNC_WAIT, COLLECT, PARITY} state_t;
`else
    typedef enum logic {SYNC_WAIT, COLLECT} state_t;
`endif

    state_t           state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [LANES-1:0] shift_q, shift_d;
    logic [LANES-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             done;
`ifdef TDM_DEMUX_PARITY_EN
    logic             perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shift_d = shift_q;
        out_d   = out_q;
        vld_d   = vld_q;
        ovr_d   = 1'b0;
        done    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        perr_d  = perr_q;
`endif

        // Consumer takes the word; a completion below may re-assert valid.
        if (out_ready) begin
            vld_d = 1'b0;
        end

        if (in_valid) begin
            if (frame_sync) begin
                // Sync always (re)starts a frame: any partial word is silently dropped.
                shift_d    = '0;
                shift_d[0] = in_bit;
                sel_d      = SW'(1);
                state_d    = COLLECT;
            end else begin
                case (state_q)
                    SYNC_WAIT: begin
                        // Beats outside a frame are ignored until the next sync.
                    end
                    COLLECT: begin
                        shift_d[sel_q[SEL_W-1:0]] = in_bit;
                        if (sel_q == SW'(LANES - 1)) begin
`ifdef TDM_DEMUX_PARITY_EN
                            sel_d   = SW'(LANES);
                            state_d = PARITY;
`else
                            done    = 1'b1;
                            sel_d   = '0;
                            state_d = SYNC_WAIT;
`endif
                        end else begin
                            sel_d = sel_q + 1'b1;
                        end
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    PARITY: begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        done    = 1'b1;
                        perr_d  = (^shift_q) ^ in_bit;
                        sel_d   = '0;
                        state_d = SYNC_WAIT;
                    end
`endif
                    default: begin
                        state_d = SYNC_WAIT;
                        sel_d   = '0;
                    end
                endcase
            end
        end

        if (done) begin
            out_d = shift_d;
            vld_d = 1'b1;
            // Overwrite only counts as overrun if the old word is not taken this cycle.
            ovr_d = vld_q & ~out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SYNC_WAIT;
            sel_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
`ifdef TDM_DEMUX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign sel_out   = sel_q;
    assign out       = out_q;
    assign out_valid = vld_q;
    assign overrun   = ovr_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Purpose : self-checking bench for tdm_demux_1to8 with a frame-level reference model.
// Latency : model predicts per-cycle sel_out/out_valid/overrun; words go through a queue.
// Backpressure: out_ready driven directed and random to exercise hold and overwrite.

module tb_tdm_demux_1to8;
    localparam int LANES = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SW    = 4;
    localparam int FRAME = LANES + 1;
`else
    localparam int SW    = 3;
    localparam int FRAME = LANES;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_sync;
    logic             in_valid;
    logic             in_bit;
    logic             out_ready;
    logic [SW-1:0]    sel_out;
    logic [LANES-1:0] out;
    logic             out_valid;
    logic             overrun;
`ifdef TDM_DEMUX_PARITY_EN
    logic             parity_err;
`endif

    always #5 clk = ~clk;

    tdm_demux_1to8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .sel_out    (sel_out),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef TDM_DEMUX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic             perr;
        logic [LANES-1:0] w;
    } exp_t;

    exp_t q[$];   // words the consumer is expected to receive, in order

    // Reference model: position within the current frame and the bits collected so far.
    bit               in_frame;
    int               slot;
    logic [LANES-1:0] bits;
    logic             pbit;
    bit               m_vld;
    bit               m_ovr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        in_frame = 0;
        slot     = 0;
        bits     = '0;
        pbit     = 1'b0;
        m_vld    = 0;
        m_ovr    = 0;
        q.delete();
    endtask

    // One clock edge of the link as seen from the frame rules.
    task automatic model_step(input bit fs, input bit iv, input bit b, input bit rdy);
        bit   done;
        exp_t e;
        done  = 0;
        m_ovr = 0;
        if (iv) begin
            if (fs) begin
                bits     = '0;
                bits[0]  = b;
                in_frame = 1;
                slot     = 1;
            end else if (in_frame) begin
                if (slot < LANES) bits[slot] = b;
                else              pbit       = b;
                slot++;
                if (slot == FRAME) begin
                    done     = 1;
                    in_frame = 0;
                    slot     = 0;
                end
            end
        end
        if (done) begin
            e.w = bits;
`ifdef TDM_DEMUX_PARITY_EN
            e.perr = (^bits) ^ pbit;
`else
            e.perr = 1'b0;
`endif
            if (m_vld && !rdy) begin
                m_ovr = 1;
                void'(q.pop_back());
            end
            q.push_back(e);
            m_vld = 1;
        end else if (rdy) begin
            m_vld = 0;
        end
    endtask

    // Check the state left by the previous edge, then drive the next beat.
    task automatic cyc(input bit fs, input bit iv, input bit b, input bit rdy);
        @(negedge clk);
        chk("sel_out", 32'(sel_out), 32'(slot));
        chk("out_valid", 32'(out_valid), 32'(m_vld));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (m_vld && q.size() > 0) chk("out_hold", 32'(out), 32'(q[0].w));
        frame_sync = fs;
        in_valid   = iv;
        in_bit     = b;
        out_ready  = rdy;
        model_step(fs, iv, b, rdy);
    endtask

    // Parity slot (only in parity builds); rdy applies to the completing beat.
    task automatic tail(input logic [LANES-1:0] w, input bit pb_ok, input bit pb, input bit rdy);
`ifdef TDM_DEMUX_PARITY_EN
        cyc(1'b0, 1'b1, pb_ok ? ^w : pb, rdy);
`else
        if (pb_ok && pb && rdy && (w == '0)) begin
            // nothing to send in a build without a parity slot
        end
`endif
    endtask

    task automatic send_word(input logic [LANES-1:0] w, input bit rdy, input bit rdy_last);
        for (int k = 0; k < LANES; k++) begin
            cyc(k == 0, 1'b1, w[k], (k == FRAME - 1) ? rdy_last : rdy);
        end
        tail(w, 1'b1, 1'b0, rdy_last);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        frame_sync = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_sel_out", 32'(sel_out), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
    endtask

    // Monitor: whenever the consumer takes a word, it must be the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 32'(out), 32'hFFFF_FFFF);
                end else begin
                    chk("word", 32'(out), 32'(q[0].w));
`ifdef TDM_DEMUX_PARITY_EN
                    chk("parity_err", 32'(parity_err), 32'(q[0].perr));
`endif
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        frame_sync = 1'b0;
        in_valid   = 1'b0;
        in_bit     = 1'b0;
        out_ready  = 1'b0;
        model_reset();
        do_reset();

        // Single frame, held until accepted.
        send_word(8'hA5, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("a5_held", 32'(out), 32'hA5);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Gap of three idle cycles mid-frame.
        for (int k = 0; k < 4; k++) cyc(k == 0, 1'b1, k < 2 ? 1'b0 : 1'b1, 1'b0);
        idle(3, 1'b0);
        for (int k = 4; k < 8; k++) cyc(1'b0, 1'b1, k < 6 ? 1'b1 : 1'b0, 1'b0);
        tail(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("3c_word", 32'(out), 32'h3C);
        idle(1, 1'b1);

        // Partial frame aborted by a sync on its slot 5.
        for (int k = 0; k < 5; k++) cyc(k == 0, 1'b1, 1'b1, 1'b0);
        send_word(8'h0F, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("0f_word", 32'(out), 32'h0F);
        idle(1, 1'b1);

        // Back-to-back frames, no consumer: second overwrites first.
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("22_word", 32'(out), 32'h22);
        idle(1, 1'b1);

        // Same, but the consumer takes the first word on the completing edge of the second.
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b1);
        idle(2, 1'b1);

`ifdef TDM_DEMUX_PARITY_EN
        for (int k = 0; k < LANES; k++) cyc(k == 0, 1'b1, k < 3 ? 1'b1 : 1'b0, 1'b0);
        tail(8'h07, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b1);
        for (int k = 0; k < LANES; k++) cyc(k == 0, 1'b1, k < 3 ? 1'b1 : 1'b0, 1'b0);
        tail(8'h07, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
`endif

        // Random whole frames with random consumer behaviour.
        for (int i = 0; i < 30; i++) begin
            send_word(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        // Fully random beats: sporadic syncs, gaps, backpressure.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                1'($urandom), $urandom_range(0, 2) != 0);
        end

        // Reset in the middle of a frame with a word pending.
        send_word(8'h5A, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(k == 0, 1'b1, 1'b1, 1'b0);
        do_reset();
        idle(2, 1'b1);
        send_word(8'hC3, 1'b0, 1'b0);
        idle(3, 1'b1);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
